// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Glyphs are active-low, bit order gfedcba.
package seg_pkg;

  localparam logic [1:0] MODE_HEX   = 2'b00;
  localparam logic [1:0] MODE_UDEC  = 2'b01;
  localparam logic [1:0] MODE_SDEC  = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  function automatic logic [6:0] glyph(
    input logic [3:0] d
  );
    case (d)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'ha: glyph = SEG_A;
      4'hb: glyph = SEG_B;
      4'hc: glyph = SEG_C;
      4'hd: glyph = SEG_D;
      4'he: glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value/mode in, multiplexed display and busy out.
// The driver takes the slave side.
interface seg_scan_if;

  logic [7:0] value;
  logic [1:0] mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (
    output value,
    output mode,
    input  seg,
    input  an,
    input  busy
  );

  modport slave (
    input  value,
    input  mode,
    output seg,
    output an,
    output busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit double dabble: one load cycle, eight shift cycles.
// done stays high from the last shift until the next start.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [7:0]  sr;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [2:0]  cnt;
  logic        run;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Bit 8 is preloaded as the first shift: with an all-zero
  // BCD field that shift never needs an add-3 correction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      sr   <= bin[7:0];
      bcd  <= {11'd0, bin[8]};
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      {bcd, sr} <= {adj[10:0], sr, 1'b0};
      cnt       <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign units    = bcd[3:0];

endmodule

// File: rtl/seg_scan_driver.sv
// Renders an 8-bit value as hex/unsigned/signed on a
// 4-digit multiplexed seven-segment display.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000
) (
  input  logic      clk,
  input  logic      reset,
  seg_scan_if.slave bus
);

  localparam int CW =
    (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DIGIT_TICKS - 1);

  state_e          state;
  state_e          state_nx;
  logic [1:0]      lmode;
  logic [7:0]      lvalue;
  logic            lvalid;
  logic            start;
  logic            commit;
  logic            done;
  logic [8:0]      mag;
  logic [3:0]      hun;
  logic [3:0]      ten;
  logic [3:0]      uni;
  logic [3:0][6:0] disp;
  logic [3:0][6:0] glyphs;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [6:0]      seg_r;
  logic [3:0]      an_r;

  // Operand is taken from the live inputs on the start cycle,
  // the same values that get latched on that edge.
  always_comb begin
    mag = {1'b0, bus.value};
    if (bus.mode == MODE_SDEC && bus.value[7])
      mag = 9'd256 - {1'b0, bus.value};
  end

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .rst_n    (reset),
    .start    (start),
    .bin      (mag),
    .done     (done),
    .hundreds (hun),
    .tens     (ten),
    .units    (uni)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!lvalid ||
            {bus.mode, bus.value} != {lmode, lvalue}) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (done)
          state_nx = COMMIT;
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    glyphs = {4{SEG_BLANK}};
    unique case (1'b1)
      lmode == MODE_HEX: begin
        glyphs[1] = glyph(lvalue[7:4]);
        glyphs[0] = glyph(lvalue[3:0]);
      end
      lmode == MODE_UDEC,
      lmode == MODE_SDEC: begin
        if (lmode == MODE_SDEC && lvalue[7])
          glyphs[3] = SEG_MINUS;
        if (hun != 4'd0)
          glyphs[2] = glyph(hun);
        if (hun != 4'd0 || ten != 4'd0)
          glyphs[1] = glyph(ten);
        glyphs[0] = glyph(uni);
      end
      lmode == MODE_BLANK: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      lmode  <= MODE_HEX;
      lvalue <= '0;
      lvalid <= 1'b0;
      disp   <= {4{SEG_BLANK}};
    end else begin
      state <= state_nx;
      if (start) begin
        lmode  <= bus.mode;
        lvalue <= bus.value;
      end
      if (commit) begin
        disp   <= glyphs;
        lvalid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      idx   <= '0;
      seg_r <= SEG_BLANK;
      an_r  <= 4'b1111;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an_r  <= ~(4'b0001 << idx);
      seg_r <= disp[idx];
    end
  end

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver with an
// arithmetic reference model of the rendered digits.
module tb_seg_scan_driver;

  localparam int DT = 4;
  localparam logic [6:0] B = 7'b1111111;
  localparam logic [6:0] M = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc;

  seg_scan_if bus ();

  seg_scan_driver #(.DIGIT_TICKS(DT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] gl(input int d);
    case (d)
      0:  gl = 7'b1000000;
      1:  gl = 7'b1111001;
      2:  gl = 7'b0100100;
      3:  gl = 7'b0110000;
      4:  gl = 7'b0011001;
      5:  gl = 7'b0010010;
      6:  gl = 7'b0000010;
      7:  gl = 7'b1111000;
      8:  gl = 7'b0000000;
      9:  gl = 7'b0010000;
      10: gl = 7'b0001000;
      11: gl = 7'b0000011;
      12: gl = 7'b1000110;
      13: gl = 7'b0100001;
      14: gl = 7'b0000110;
      default: gl = 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0][6:0] model(
    input logic [1:0] m, input logic [7:0] v
  );
    int n, h, t, u;
    logic [3:0][6:0] r;
    r = {B, B, B, B};
    n = int'(v);
    if (m == 2'b00) begin
      r[1] = gl(n / 16);
      r[0] = gl(n % 16);
    end else if (m != 2'b11) begin
      if (m == 2'b10 && n >= 128) begin
        n = 256 - n;
        r[3] = M;
      end
      h = n / 100;
      t = (n / 10) % 10;
      u = n % 10;
      if (h != 0) r[2] = gl(h);
      if (h != 0 || t != 0) r[1] = gl(t);
      r[0] = gl(u);
    end
    return r;
  endfunction

  task automatic apply(input logic [1:0] m,
                       input logic [7:0] v);
    bus.mode  = m;
    bus.value = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Busy-high sample count after an input change; -1 if none.
  task automatic busy_period(output int n);
    int k;
    n = 0;
    k = 0;
    while (!bus.busy && k < 4) begin
      step();
      k++;
    end
    if (!bus.busy) begin
      n = -1;
      return;
    end
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic read_display(output logic [3:0][6:0] d);
    d = 'x;
    step();
    repeat (20) begin
      step();
      for (int i = 0; i < 4; i++)
        if (bus.an == ~(4'b0001 << i)) d[i] = bus.seg;
    end
  endtask

  task automatic test_reset();
    logic [3:0][6:0] d, e;
    apply(2'b00, 8'h00);
    repeat (2) step();
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7F ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_out an=%b seg=%h busy=%b want 1111/7f/0",
               bus.an, bus.seg, bus.busy);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      checks++;
      if (bus.busy !== (j <= 10)) begin
        failures++;
        $display("FAIL reset_busy cyc%0d got %b want %b",
                 j, bus.busy, j <= 10);
      end
      if (j == 1) begin
        checks++;
        if (bus.an !== 4'b1110) begin
          failures++;
          $display("FAIL first_an got %b want 1110", bus.an);
        end
      end
    end
    read_display(d);
    e = {B, B, 7'b1000000, 7'b1000000};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d[i] !== e[i]) begin
        failures++;
        $display("FAIL reset_disp digit%0d got %b want %b",
                 i, d[i], e[i]);
      end
    end
  endtask

  task automatic run_case(input string nm,
                          input logic [1:0] m,
                          input logic [7:0] v);
    int n;
    logic [3:0][6:0] d, e;
    apply(m, v);
    busy_period(n);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL %s_latency m=%b v=%h got %0d want 10",
               nm, m, v, n);
    end
    read_display(d);
    e = model(m, v);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d[i] !== e[i]) begin
        failures++;
        $display("FAIL %s m=%b v=%h digit%0d got %b want %b",
                 nm, m, v, i, d[i], e[i]);
      end
    end
  endtask

  task automatic test_hex();
    run_case("hex", 2'b00, 8'hA5);
  endtask

  task automatic test_udec();
    run_case("udec", 2'b01, 8'hFF);
    run_case("udec", 2'b01, 8'h07);
  endtask

  task automatic test_sdec();
    run_case("sdec", 2'b10, 8'h80);
    run_case("sdec", 2'b10, 8'hF6);
    run_case("blank", 2'b11, 8'h3C);
  endtask

  task automatic test_random();
    logic [1:0] m, pm;
    logic [7:0] v, pv;
    pm = bus.mode;
    pv = bus.value;
    for (int k = 0; k < 16; k++) begin
      m = 2'($urandom_range(0, 3));
      v = 8'($urandom);
      if (m == pm && v == pv) v = ~v;
      run_case("rand", m, v);
      pm = m;
      pv = v;
    end
  endtask

  task automatic test_scan();
    logic [3:0][6:0] e;
    int ix;
    e = model(bus.mode, bus.value);
    for (int k = 0; k < 40; k++) begin
      step();
      ix = ((cyc - 1) / DT) % 4;
      checks++;
      if (bus.an !== ~(4'b0001 << ix) ||
          bus.seg !== e[ix]) begin
        failures++;
        $display("FAIL scan cyc=%0d an=%b seg=%b want %b/%b",
                 cyc, bus.an, bus.seg,
                 ~(4'b0001 << ix), e[ix]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][6:0] d, e;
    logic want;
    apply(2'b01, 8'h10);
    for (int j = 1; j <= 25; j++) begin
      step();
      want = (j <= 10) || (j >= 12 && j <= 21);
      checks++;
      if (bus.busy !== want) begin
        failures++;
        $display("FAIL b2b_busy cyc%0d got %b want %b",
                 j, bus.busy, want);
      end
      if (j == 3) apply(2'b01, 8'h20);
    end
    read_display(d);
    e = {B, B, 7'b0110000, 7'b0100100};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d[i] !== e[i]) begin
        failures++;
        $display("FAIL b2b_disp digit%0d got %b want %b",
                 i, d[i], e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][6:0] d, e;
    apply(2'b00, 8'h55);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'h7F ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset an=%b seg=%h busy=%b want 1111/7f/0",
               bus.an, bus.seg, bus.busy);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      checks++;
      if (bus.busy !== (j <= 10)) begin
        failures++;
        $display("FAIL mid_busy cyc%0d got %b want %b",
                 j, bus.busy, j <= 10);
      end
    end
    read_display(d);
    e = model(2'b00, 8'h55);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d[i] !== e[i]) begin
        failures++;
        $display("FAIL mid_disp digit%0d got %b want %b",
                 i, d[i], e[i]);
      end
    end
  endtask

  initial begin
    bus.mode  = 2'b00;
    bus.value = 8'h00;
    #1;
    test_reset();
    test_hex();
    test_udec();
    test_sdec();
    test_scan();
    test_random();
    test_back_to_back();
    test_scan();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Output-side companion to the switch/button ALU front end. Takes the 8-bit ALU result Y and drives the 4-digit multiplexed seven-segment display (seg/an). Renders the value in one of three modes: hex, unsigned decimal, or signed decimal. A sequential double-dabble FSM converts to BCD, and a refresh counter scans the digits.

Parameters:
DIGIT_TICKS, 100000, clk cycles each digit is enabled (1 ms at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
value  input  8  ALU result Y to display
mode  input  2  00 hex, 01 unsigned decimal, 10 signed decimal, 11 blank
seg  output  7  segment drive, active-low; seg[0]=a … seg[6]=g
an  output  4  digit enables, active-low; an[0] = rightmost digit
busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (reset=0, async):
  - an=4'b1111, seg=7'h7F, busy=0.
  - Scan counter=0, digit index=0, FSM=IDLE.
  - Display register = all blank; "latched valid" flag cleared.
- Reset mid-conversion aborts it; nothing is committed.
- FSM IDLE:
  - Each cycle, compare {mode,value} with the latched copy.
  - On a mismatch, or when the valid flag is clear: latch the inputs, set busy=1, go to SHIFT.
- FSM SHIFT:
  - 8 cycles of double dabble on a magnitude operand, then go to COMMIT.
  - Operand is value for hex/unsigned modes, |value| for signed mode.
  - |0x80| = 128; a 9-bit internal magnitude is used.
- FSM COMMIT, 1 cycle:
  - Build 4 glyphs, write the display register atomically, set the valid flag, busy=0, go to IDLE.
- Latency: input change at cycle N gives display register updated at the end of cycle N+10. All modes take the same latency.
- Input changes while busy are ignored until IDLE. IDLE then re-compares, so the final value is never dropped.
- Glyph rules (digit3..digit0):
  - hex: blank, blank, value[7:4], value[3:0].
  - unsigned: blank, hundreds, tens, units.
  - signed: '-' if value[7]=1 else blank, then hundreds, tens, units.
  - Decimal leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; units always shown.
  - mode 11: all blank.
- Scan:
  - Counter runs 0..DIGIT_TICKS-1.
  - On wrap, the digit index increments 0→1→2→3→0.
  - seg/an are registered: one cycle after an index change, an=~(1<<index) and seg=display[index].
  - After reset release, digit0 is enabled from the first clock.
- Scanning and conversion run independently. A commit takes effect at the next registered seg update, with no partial digits.

Decomposition:
- Package seg_pkg holds:
  - mode constants: MODE_HEX, MODE_UDEC, MODE_SDEC, MODE_BLANK.
  - glyph constants, active-low gfedcba:
    - digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - letters: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
    - SEG_BLANK=1111111, SEG_MINUS=0111111.
  - FSM state typedef: IDLE, SHIFT, COMMIT.
- One sub-module: bin2bcd_seq, a 9-bit double dabble with start/done, producing hundreds/tens/units.
- The top level keeps the compare/latch, glyph build, display register and scan logic.

Test Plan:
All tests use DIGIT_TICKS=4.
1. Reset low → an=1111, seg=7F, busy=0. Release with value=0x00, mode=00 → busy high cycles 1–10. Then digit0=1000000, digit1=1000000, digits 2 and 3 = 1111111.
2. mode=00, value=0xA5 → digit1=0001000 (A), digit0=0010010 (5), digits 3 and 2 blank.
3. mode=01, value=0xFF → digits 2..0 = 2,5,5 and digit3 blank. Then value=0x07 → digits 3..1 blank, digit0=1111000.
4. mode=10, value=0x80 → digit3=0111111, then 1,2,8. Then value=0xF6 → digit3 '-', digit2 blank, digit1 '1', digit0 '0'.
5. Scan: an sequence 1110,1101,1011,0111, each held exactly 4 cycles and wrapping. seg always matches the enabled digit.
6. Change 0x10→0x20 (mode 01) at SHIFT cycle 3 → 0x10 committed first, then a second busy period, final display 0x20 (shown as 32). Reset pulsed mid-SHIFT → blank outputs immediately, busy=0, and a fresh conversion starts after release.
